// File: rtl/inst_align_buffer.sv
// Instruction realignment buffer: fetches 32-bit words into a halfword queue and
// presents one whole RVC or 32-bit instruction per handshake, including word straddlers.
module inst_align_buffer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        fetch_req,
    output logic [31:0] fetch_addr,
    input  logic        fetch_ack,
    input  logic [31:0] fetch_data,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_FLUSH} state_t;

    state_t      state, state_nxt;
    logic [63:0] hw_buf, buf_nxt, buf_shift, app;
    logic [2:0]  hw_cnt, cnt_nxt, cnt_shift;
    logic [31:0] pc, pc_nxt, fptr, fptr_nxt, req_addr, req_addr_nxt;
    logic        skip_low, skip_nxt;
    logic        head_rvc, consume, accept;

    assign head_rvc   = hw_buf[1:0] != 2'b11;
    assign inst_valid = (hw_cnt != 3'd0) && (head_rvc || hw_cnt >= 3'd2);
    assign inst_out   = head_rvc ? {16'h0, hw_buf[15:0]} : hw_buf[31:0];
    assign inst_pc    = pc;

    // Once a request is outstanding it stays up until acked; a new one only starts with room for a word.
    assign fetch_req  = !rst && ((state != S_REQ) || (hw_cnt <= 3'd2));
    assign fetch_addr = (state == S_REQ) ? fptr : req_addr;

    assign consume = inst_valid && inst_ready && !redirect;
    assign accept  = fetch_req && fetch_ack && (state != S_FLUSH) && !redirect;

    assign buf_shift = !consume ? hw_buf : (head_rvc ? (hw_buf >> 16) : (hw_buf >> 32));
    assign cnt_shift = !consume ? hw_cnt : (hw_cnt - (head_rvc ? 3'd1 : 3'd2));
    assign app       = skip_low ? {48'h0, fetch_data[31:16]} : {32'h0, fetch_data};

    always_comb begin
        buf_nxt      = buf_shift;
        cnt_nxt      = cnt_shift;
        pc_nxt       = consume ? pc + (head_rvc ? 32'd2 : 32'd4) : pc;
        fptr_nxt     = fptr;
        skip_nxt     = skip_low;
        state_nxt    = state;
        req_addr_nxt = req_addr;

        // Unused queue slots are always zero, so appending is a plain OR at the post-consume tail.
        if (accept) begin
            buf_nxt  = buf_shift | (app << {cnt_shift, 4'b0});
            cnt_nxt  = cnt_shift + (skip_low ? 3'd1 : 3'd2);
            skip_nxt = 1'b0;
            fptr_nxt = fptr + 32'd4;
        end

        case (state)
            S_REQ: begin
                if (fetch_req && !fetch_ack) begin
                    state_nxt    = S_WAIT;
                    req_addr_nxt = fptr;
                end
            end
            S_WAIT:  if (fetch_ack) state_nxt = S_REQ;
            S_FLUSH: if (fetch_ack) state_nxt = S_REQ;
            default: state_nxt = S_REQ;
        endcase

        // An unacked request in flight must be drained before the new stream's first fetch.
        if (redirect) begin
            buf_nxt   = 64'h0;
            cnt_nxt   = 3'd0;
            pc_nxt    = redirect_pc & 32'hFFFF_FFFE;
            fptr_nxt  = redirect_pc & 32'hFFFF_FFFC;
            skip_nxt  = redirect_pc[1];
            state_nxt = (fetch_req && !fetch_ack) ? S_FLUSH : S_REQ;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_REQ;
            hw_buf   <= 64'h0;
            hw_cnt   <= 3'd0;
            pc       <= RESET_PC & 32'hFFFF_FFFE;
            fptr     <= RESET_PC & 32'hFFFF_FFFC;
            req_addr <= RESET_PC & 32'hFFFF_FFFC;
            skip_low <= RESET_PC[1];
        end else begin
            state    <= state_nxt;
            hw_buf   <= buf_nxt;
            hw_cnt   <= cnt_nxt;
            pc       <= pc_nxt;
            fptr     <= fptr_nxt;
            req_addr <= req_addr_nxt;
            skip_low <= skip_nxt;
        end
    end
endmodule

// File: tb/tb_inst_align_buffer.sv
// Bench for inst_align_buffer: instruction stream predicted by decoding memory at the
// expected PC; fetch responder with randomized latency; directed scenarios then random traffic.
module tb_inst_align_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req, fetch_ack, inst_valid, inst_ready, redirect;
    logic [31:0] fetch_addr, fetch_data, inst_out, inst_pc, redirect_pc;

    inst_align_buffer #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .fetch_data(fetch_data),
        .inst_out(inst_out), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    logic [31:0] ovr [logic [31:0]];
    logic [31:0] seed;
    int          n_asrt = 0, n_fail = 0;
    int          bcount, wait_n, lat, lat_lo, lat_hi, hs;
    logic [31:0] exp_pc, exp_fa;
    bit          skip, stale;

    // Memory: directed words override a hash-generated background image.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] x;
        if (ovr.exists(a)) return ovr[a];
        x = (a ^ seed) * 32'h9E37_79B1;
        x = x ^ (x >> 15);
        x = x * 32'h85EB_CA6B;
        return x ^ (x >> 13);
    endfunction

    function automatic logic [15:0] hw16(input logic [31:0] p);
        logic [31:0] w;
        w = mem_word({p[31:2], 2'b00});
        return p[1] ? w[31:16] : w[15:0];
    endfunction

    function automatic bit is_rvc(input logic [31:0] p);
        logic [15:0] h;
        h = hw16(p);
        return h[1:0] != 2'b11;
    endfunction

    function automatic logic [31:0] exp_inst(input logic [31:0] p);
        if (is_rvc(p)) return {16'h0, hw16(p)};
        return {hw16(p + 32'd2), hw16(p)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_lat(input int lo, input int hi);
        lat_lo = lo;
        lat_hi = hi;
        lat    = $urandom_range(hi, lo);
    endtask

    // One clock: drive inputs, check outputs against the model, advance the model, step the clock.
    task automatic cycle(input bit rdy, input bit rd, input logic [31:0] rpc);
        bit ev, legit;
        int len;
        inst_ready  = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        if (fetch_req && wait_n >= lat) begin
            fetch_ack  = 1'b1;
            fetch_data = mem_word(fetch_addr);
        end else begin
            fetch_ack  = 1'b0;
            fetch_data = $urandom;
            if (fetch_req) wait_n++;
        end
        #1;
        len = is_rvc(exp_pc) ? 1 : 2;
        ev  = (bcount >= 1) && (len == 1 || bcount >= 2);
        check("fetch_req", {31'h0, fetch_req}, {31'h0, bcount <= 2});
        check("inst_valid", {31'h0, inst_valid}, {31'h0, ev});
        if (ev) begin
            check("inst_out", inst_out, exp_inst(exp_pc));
            check("inst_pc", inst_pc, exp_pc);
        end
        legit = 1'b0;
        if (fetch_ack) begin
            if (stale) stale = 1'b0;
            else begin
                legit = 1'b1;
                check("fetch_addr", fetch_addr, exp_fa);
            end
        end
        if (ev && rdy && !rd) begin
            bcount -= len;
            exp_pc += 32'(len * 2);
            hs++;
        end
        if (legit && !rd) begin
            bcount += skip ? 1 : 2;
            skip    = 1'b0;
            exp_fa += 32'd4;
        end
        if (rd) begin
            stale  = fetch_req && !fetch_ack;
            bcount = 0;
            exp_pc = rpc & 32'hFFFF_FFFE;
            exp_fa = rpc & 32'hFFFF_FFFC;
            skip   = rpc[1];
        end
        if (fetch_ack) begin
            wait_n = 0;
            lat    = $urandom_range(lat_hi, lat_lo);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_until(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (hs < target && n < budget) begin
            cycle(1'b1, 1'b0, 32'h0);
            n++;
        end
        check(tag, {31'h0, hs >= target}, 32'h1);
    endtask

    initial begin
        int start;
        logic [31:0] tgt;
        seed = $urandom;
        rst = 1'b1; fetch_ack = 1'b0; fetch_data = 32'h0;
        inst_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        bcount = 0; exp_pc = 32'h0; exp_fa = 32'h0; skip = 1'b0; stale = 1'b0;
        wait_n = 0; hs = 0;
        set_lat(0, 0);

        ovr[32'h000] = 32'h0000_0013; ovr[32'h004] = 32'h0010_0093;
        ovr[32'h200] = 32'h4585_4505;
        ovr[32'h300] = 32'h0013_4505; ovr[32'h304] = 32'h4585_0000;
        ovr[32'h100] = 32'h4505_FFFF;
        ovr[32'h600] = 32'h0000_0013; ovr[32'h604] = 32'h0010_0093;
        ovr[32'h608] = 32'h0020_0113; ovr[32'h60C] = 32'h0030_0193;

        #3;
        check("rst_fetch_req", {31'h0, fetch_req}, 32'h0);
        check("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
        check("rst_inst_out", inst_out, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Sequential 32-bit stream from reset, zero-latency memory
        run_until("t1_progress", 4, 20);

        // Two RVC instructions in one word
        cycle(1'b1, 1'b1, 32'h200);
        run_until("t2_progress", hs + 2, 10);

        // 32-bit instruction straddling a word boundary, slow memory
        set_lat(2, 2);
        cycle(1'b1, 1'b1, 32'h300);
        run_until("t3_progress", hs + 3, 30);

        // Redirect to odd halfword: low half of the first word is discarded
        set_lat(0, 0);
        cycle(1'b1, 1'b1, 32'h102);
        check("t4_fetch_addr", fetch_addr, 32'h100);
        check("t4_fetch_req", {31'h0, fetch_req}, 32'h1);
        run_until("t4_progress", hs + 2, 10);

        // Redirect while a delayed fetch is outstanding
        set_lat(3, 3);
        cycle(1'b1, 1'b1, 32'h400);
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 32'h500);
        run_until("t5_progress", hs + 3, 40);

        // Backpressure with 32-bit instructions
        set_lat(0, 0);
        cycle(1'b0, 1'b1, 32'h600);
        repeat (6) cycle(1'b0, 1'b0, 32'h0);
        check("t6_req_drop", {31'h0, fetch_req}, 32'h0);
        check("t6_hold_pc", inst_pc, 32'h600);
        check("t6_hold_inst", inst_out, 32'h0000_0013);
        start = hs;
        run_until("t6_progress", start + 4, 10);

        // Random traffic: variable latency, backpressure, redirects (including PC wrap)
        set_lat(0, 3);
        start = hs;
        repeat (3000) begin
            if ($urandom_range(99, 0) < 3) begin
                case ($urandom_range(3, 0))
                    0:       tgt = 32'hFFFF_FFFA;
                    1:       tgt = 32'hFFFF_FFFE;
                    default: tgt = $urandom & 32'h0000_FFFF;
                endcase
                cycle($urandom_range(99, 0) < 70, 1'b1, tgt);
            end else begin
                cycle($urandom_range(99, 0) < 70, 1'b0, 32'h0);
            end
        end
        check("rand_progress", {31'h0, hs >= start + 200}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule

// File: doc/inst_align_buffer.md
Name: inst_align_buffer

Overview:
- Fetch-side instruction realignment buffer; sits directly upstream of the decompression unit.
- Fetches 32-bit words from instruction memory and keeps a small halfword queue.
- Presents one complete instruction per handshake on inst_out: a 16-bit RVC instruction in the low half, or a full 32-bit instruction, including ones that straddle a word boundary.
- Advances its PC by 2 or 4 and supports branch/jump redirects.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first instruction after reset; bit 0 ignored.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- fetch_req  output  1  word fetch request; held high until fetch_ack
- fetch_addr  output  32  byte address of requested word, bits[1:0]=00; stable while fetch_req high
- fetch_ack  input  1  fetch_data valid this cycle; may assert in the same cycle as fetch_req
- fetch_data  input  32  fetched word, little-endian halfwords
- inst_out  output  32  aligned instruction; upper 16 bits are 0 when compressed
- inst_pc  output  32  PC of inst_out
- inst_valid  output  1  inst_out/inst_pc valid
- inst_ready  input  1  consumer accepts this cycle
- redirect  input  1  flush and restart at redirect_pc
- redirect_pc  input  32  new PC; bit 0 ignored

Behaviour:
- State:
  - 64-bit halfword queue buf (head at buf[15:0]) and hw_cnt (0..4).
  - pc, fptr (next word address), skip_low flag.
  - FSM: S_REQ, S_WAIT, S_FLUSH.
- Reset (async):
  - hw_cnt=0, pc=RESET_PC&~1, fptr=RESET_PC&~3, skip_low=RESET_PC[1], state S_REQ.
  - Outputs during reset: fetch_req=0, inst_valid=0, inst_out=0, inst_pc=RESET_PC&~1.
- Instruction length: head halfword buf[1:0]!=2'b11 means compressed (1 halfword); otherwise 2 halfwords.
- inst_valid (from registers only): hw_cnt>=1 and (head compressed or hw_cnt>=2).
  - inst_out={16'h0,buf[15:0]} if compressed, else buf[31:0].
- Consume: on inst_valid&&inst_ready, shift buf right by 16 or 32 bits, hw_cnt -=1 or 2, pc +=2 or 4 (wraps mod 2^32).
- Fetch FSM:
  - S_REQ: fetch_req=1 when hw_cnt<=2, evaluated after this cycle's consume is ignored, i.e. on the current registered hw_cnt; fetch_addr=fptr. Without ack, go to S_WAIT (or stay if no request). With ack, accept data.
  - S_WAIT: fetch_req=1 and fetch_addr unchanged. On ack, accept data and go to S_REQ.
  - S_FLUSH: fetch_req=1 with the stale address held. On ack, discard the data and go to S_REQ.
- Accept data:
  - If skip_low: append fetch_data[31:16] (1 halfword) and clear skip_low.
  - Otherwise append both halves (low first).
  - fptr += 4.
  - Append at the post-consume count when consume and ack coincide.
  - Overflow is impossible: one outstanding request, issued only at hw_cnt<=2.
- Redirect has priority over consume and accept in the same cycle:
  - Next state: hw_cnt=0, pc=redirect_pc&~1, fptr=redirect_pc&~3, skip_low=redirect_pc[1].
  - A same-cycle consume has no effect.
  - Request outstanding (S_WAIT, or S_REQ with fetch_req high) and no ack this cycle: go to S_FLUSH.
  - Ack in the same cycle as redirect: data dropped, go to S_REQ.
  - Redirect while in S_FLUSH: stay in S_FLUSH with the new fptr.
- Latency: redirect at cycle N, fetch_req at N+1; with same-cycle ack, inst_valid at N+2.
- Backpressure: while inst_valid&&!inst_ready, inst_out and inst_pc hold stable.

Test Plan:
1. RESET_PC=0, word@0=32'h0000_0013, word@4=32'h0010_0093, inst_ready=1, same-cycle ack -> inst_out 0x00000013 pc 0, then 0x00100093 pc 4, one instruction per cycle once the queue primes.
2. word@0=32'h4585_4505 -> 0x00004505 pc 0, then 0x00004585 pc 2; next fetch_addr 4.
3. Straddle: word@0=32'h0013_4505, word@4=32'h4585_0000 -> 0x00004505 pc 0; 0x00000013 pc 2 asserted valid only after word@4 acked; then 0x00004585 pc 6.
4. Redirect to 32'h0000_0102, word@0x100=32'h4505_FFFF -> fetch_addr 0x100, low half discarded, first inst_out 0x00004505 pc 0x102.
5. Redirect while S_WAIT (ack delayed 3 cycles) -> stale ack data never appears on inst_out; next fetch_addr equals redirect target.
6. inst_ready low 6 cycles with 32-bit instructions -> inst_out/inst_pc stable, fetch_req drops once hw_cnt=4. Release inst_ready -> pcs 0,4,8,12 in order, none lost or duplicated.
